// File: rtl/data_mem_responder.sv
// Word-addressed 64-bit data memory acting as the responder on the core data interface.
// Fixed wait-state latency, one-cycle ready pulse, and a side loader port for preload.
module data_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              data_mem_addr,
  input  logic                     data_mem_addr_valid,
  input  logic                     data_mem_rw,
  input  logic [63:0]              data_mem_data_w,
  output logic [63:0]              data_mem_data_r,
  output logic                     data_mem_ready,
  output logic                     data_mem_err,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [63:0]              ld_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r, state_n_s;
  logic [3:0]        cnt_r, cnt_n_s;
  logic              accept_s, enter_resp_s;

  logic [63:0]       mem_r [DEPTH];
  logic [AW-1:0]     idx_r;
  logic              rw_r, bad_r;
  logic [63:0]       wdata_r;

  logic [63:0]       off_s;
  logic [AW-1:0]     in_idx_s, sel_idx_s;
  logic              in_bad_s, sel_rw_s, sel_bad_s;
  logic [63:0]       sel_wdata_s;

  logic              ready_r, err_r;
  logic [63:0]       data_r_r;

  assign off_s    = data_mem_addr - BASE_ADDR;
  assign in_idx_s = off_s[AW+2:3];
  assign in_bad_s = (data_mem_addr[2:0] != 3'd0) || (data_mem_addr < BASE_ADDR) ||
                    ((off_s >> 3) >= 64'(DEPTH));

  // Next-state and counter logic; the loader owns the IDLE cycle when it strobes.
  always_comb begin
    state_n_s    = state_r;
    cnt_n_s      = cnt_r;
    accept_s     = 1'b0;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (ld_we) begin
          state_n_s = IDLE;
        end else if (data_mem_addr_valid) begin
          accept_s = 1'b1;
          if (LATENCY == 1) begin
            state_n_s    = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_n_s = WAIT;
            cnt_n_s   = CNT_INIT;
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_n_s    = RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_n_s = cnt_r - 4'd1;
        end
      end
      RESP:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // With LATENCY==1 the response is entered on the accept edge, before the latch is loaded.
  always_comb begin
    sel_idx_s   = idx_r;
    sel_rw_s    = rw_r;
    sel_wdata_s = wdata_r;
    sel_bad_s   = bad_r;
    if (state_r == IDLE) begin
      sel_idx_s   = in_idx_s;
      sel_rw_s    = data_mem_rw;
      sel_wdata_s = data_mem_data_w;
      sel_bad_s   = in_bad_s;
    end else begin
      sel_idx_s   = idx_r;
      sel_rw_s    = rw_r;
      sel_wdata_s = wdata_r;
      sel_bad_s   = bad_r;
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  // Request latch so later input changes cannot disturb the transaction.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      idx_r   <= in_idx_s;
      rw_r    <= data_mem_rw;
      wdata_r <= data_mem_data_w;
      bad_r   <= in_bad_s;
    end
  end

  // Registered response outputs; read data only moves on a read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r  <= 1'b0;
      err_r    <= 1'b0;
      data_r_r <= 64'h0;
    end else if (enter_resp_s) begin
      ready_r <= 1'b1;
      err_r   <= sel_bad_s;
      if (!sel_rw_s) begin
        data_r_r <= sel_bad_s ? 64'h0 : mem_r[sel_idx_s];
      end
    end else begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
    end
  end

  // Storage: loader writes in IDLE, core writes commit on the response entry edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((state_r == IDLE) && ld_we) begin
        mem_r[ld_idx] <= ld_data;
      end else if (enter_resp_s && sel_rw_s && !sel_bad_s) begin
        mem_r[sel_idx_s] <= sel_wdata_s;
      end
    end
  end

  assign data_mem_ready  = ready_r;
  assign data_mem_err    = err_r;
  assign data_mem_data_r = data_r_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with LATENCY 2, 1 and 15,
// each exercised through a bounded request task with hand-computed expectations.
module tb_data_mem_responder;

  logic        clk;
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  logic        rst_s      [3];
  logic [63:0] addr_s     [3];
  logic        valid_s    [3];
  logic        rw_s       [3];
  logic [63:0] wdata_s    [3];
  logic [63:0] rdata_s    [3];
  logic        ready_s    [3];
  logic        err_s      [3];
  logic        ld_we_s    [3];
  logic [9:0]  ld_idx_s   [3];
  logic [63:0] ld_data_s  [3];

  data_mem_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(64'h0)) dut_l2 (
    .clk(clk), .rst(rst_s[0]), .data_mem_addr(addr_s[0]), .data_mem_addr_valid(valid_s[0]),
    .data_mem_rw(rw_s[0]), .data_mem_data_w(wdata_s[0]), .data_mem_data_r(rdata_s[0]),
    .data_mem_ready(ready_s[0]), .data_mem_err(err_s[0]), .ld_we(ld_we_s[0]),
    .ld_idx(ld_idx_s[0]), .ld_data(ld_data_s[0]));

  data_mem_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(64'h0)) dut_l1 (
    .clk(clk), .rst(rst_s[1]), .data_mem_addr(addr_s[1]), .data_mem_addr_valid(valid_s[1]),
    .data_mem_rw(rw_s[1]), .data_mem_data_w(wdata_s[1]), .data_mem_data_r(rdata_s[1]),
    .data_mem_ready(ready_s[1]), .data_mem_err(err_s[1]), .ld_we(ld_we_s[1]),
    .ld_idx(ld_idx_s[1]), .ld_data(ld_data_s[1]));

  data_mem_responder #(.DEPTH(1024), .LATENCY(15), .BASE_ADDR(64'h0)) dut_l15 (
    .clk(clk), .rst(rst_s[2]), .data_mem_addr(addr_s[2]), .data_mem_addr_valid(valid_s[2]),
    .data_mem_rw(rw_s[2]), .data_mem_data_w(wdata_s[2]), .data_mem_data_r(rdata_s[2]),
    .data_mem_ready(ready_s[2]), .data_mem_err(err_s[2]), .ld_we(ld_we_s[2]),
    .ld_idx(ld_idx_s[2]), .ld_data(ld_data_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure acceptance spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input logic [9:0] idx, input logic [63:0] data);
    ld_we_s[k]   = 1'b1;
    ld_idx_s[k]  = idx;
    ld_data_s[k] = data;
    tick();
    ld_we_s[k] = 1'b0;
  endtask

  // Issue one request; lat counts edges from the first edge the request is presented at.
  task automatic do_req(input int k, input logic rw, input logic [63:0] addr,
                        input logic [63:0] wd, input bit with_ld, output int lat,
                        output logic [63:0] rd, output logic er, output int acc);
    logic [63:0] prev;
    bit          seen;
    int          skip;
    prev = rdata_s[k];
    seen = 1'b0;
    lat  = 0;
    rd   = 64'h0;
    er   = 1'b0;
    acc  = 0;
    skip = with_ld ? 2 : 1;
    addr_s[k]  = addr;
    rw_s[k]    = rw;
    wdata_s[k] = wd;
    valid_s[k] = 1'b1;
    for (int n = 1; n <= 40 && !seen; n++) begin
      tick();
      if (n == 1) ld_we_s[k] = 1'b0;
      if (n == skip) begin
        valid_s[k] = 1'b0;
        acc = cyc;
      end
      if (ready_s[k] === 1'b1) begin
        seen = 1'b1;
        lat  = n;
        rd   = rdata_s[k];
        er   = err_s[k];
      end else begin
        chk("data_r_stable_wait", rdata_s[k], prev);
      end
    end
    chk("ready_seen", 64'(seen), 64'd1);
    if (rw) chk("data_r_stable_wr", rd, prev);
    tick();
    chk("ready_one_cycle", 64'(ready_s[k]), 64'd0);
    chk("err_one_cycle", 64'(err_s[k]), 64'd0);
  endtask

  initial begin
    int          lat, acc, acc1;
    logic [63:0] rd;
    logic        er;

    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1; addr_s[k] = 64'h0; valid_s[k] = 1'b0; rw_s[k] = 1'b0;
      wdata_s[k] = 64'h0; ld_we_s[k] = 1'b0; ld_idx_s[k] = 10'd0; ld_data_s[k] = 64'h0;
    end
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 64'(ready_s[k]), 64'd0);
      chk("rst_err", 64'(err_s[k]), 64'd0);
      chk("rst_data_r", rdata_s[k], 64'h0);
      rst_s[k] = 1'b0;
    end
    tick();

    // Loader preload and simple read.
    load(0, 10'd5, 64'hDEAD_BEEF_0000_0005);
    load(0, 10'd0, 64'hCAFE_0000_0000_0000);
    load(0, 10'd2, 64'h0);
    do_req(0, 1'b0, 64'h28, 64'h0, 1'b0, lat, rd, er, acc);
    chk("t1_lat", 64'(lat), 64'd2);
    chk("t1_data", rd, 64'hDEAD_BEEF_0000_0005);
    chk("t1_err", 64'(er), 64'd0);

    // Back-to-back write then read of the same word.
    do_req(0, 1'b1, 64'h40, 64'h1122_3344_5566_7788, 1'b0, lat, rd, er, acc1);
    chk("t2_wr_lat", 64'(lat), 64'd2);
    chk("t2_wr_err", 64'(er), 64'd0);
    do_req(0, 1'b0, 64'h40, 64'h0, 1'b0, lat, rd, er, acc);
    chk("t2_period", 64'(acc - acc1), 64'd3);
    chk("t2_rd_data", rd, 64'h1122_3344_5566_7788);

    // Bad accesses.
    do_req(0, 1'b0, 64'h43, 64'h0, 1'b0, lat, rd, er, acc);
    chk("t3_mis_err", 64'(er), 64'd1);
    chk("t3_mis_data", rd, 64'h0);
    do_req(0, 1'b0, 64'd8192, 64'h0, 1'b0, lat, rd, er, acc);
    chk("t3_oor_err", 64'(er), 64'd1);
    chk("t3_oor_data", rd, 64'h0);
    do_req(0, 1'b1, 64'd8192, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, rd, er, acc);
    chk("t3_oor_wr_err", 64'(er), 64'd1);
    do_req(0, 1'b0, 64'h0, 64'h0, 1'b0, lat, rd, er, acc);
    chk("t3_mem0_kept", rd, 64'hCAFE_0000_0000_0000);
    chk("t3_mem0_err", 64'(er), 64'd0);

    // Loader and core request in the same IDLE cycle.
    ld_we_s[0] = 1'b1; ld_idx_s[0] = 10'd3; ld_data_s[0] = 64'hA5;
    do_req(0, 1'b0, 64'h18, 64'h0, 1'b1, lat, rd, er, acc);
    chk("t4_lat", 64'(lat), 64'd3);
    chk("t4_data", rd, 64'hA5);

    // Reset in WAIT abandons the write.
    addr_s[0] = 64'h10; rw_s[0] = 1'b1; wdata_s[0] = 64'h77; valid_s[0] = 1'b1;
    tick();
    valid_s[0] = 1'b0;
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    chk("t5_ready", 64'(ready_s[0]), 64'd0);
    chk("t5_err", 64'(err_s[0]), 64'd0);
    chk("t5_data_r", rdata_s[0], 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_ready", 64'(ready_s[0]), 64'd0);
    end
    do_req(0, 1'b0, 64'h10, 64'h0, 1'b0, lat, rd, er, acc);
    chk("t5_mem2", rd, 64'h0);
    chk("t5_lat", 64'(lat), 64'd2);

    // LATENCY=1 and LATENCY=15 instances.
    for (int k = 1; k < 3; k++) begin
      load(k, 10'd7, 64'h0BAD_F00D_0000_0007 + 64'(k));
      do_req(k, 1'b0, 64'h38, 64'h0, 1'b0, lat, rd, er, acc);
      chk("t6_rd_lat", 64'(lat), (k == 1) ? 64'd1 : 64'd15);
      chk("t6_rd_data", rd, 64'h0BAD_F00D_0000_0007 + 64'(k));
      do_req(k, 1'b1, 64'h38, 64'h5555_AAAA_0000_0000, 1'b0, lat, rd, er, acc1);
      chk("t6_wr_lat", 64'(lat), (k == 1) ? 64'd1 : 64'd15);
      chk("t6_hold_after_wr", rdata_s[k], 64'h0BAD_F00D_0000_0007 + 64'(k));
      do_req(k, 1'b0, 64'h38, 64'h0, 1'b0, lat, rd, er, acc);
      chk("t6_period", 64'(acc - acc1), (k == 1) ? 64'd2 : 64'd16);
      chk("t6_raw_data", rd, 64'h5555_AAAA_0000_0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
